uart_tx_flex: RTL

//  Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Serialises DATA_BITS
//  LSB-first with optional even/odd parity and 1 or 2 stop bits, chosen per frame.
//  One-entry holding buffer behind a valid/ready handshake allows gapless back-to-back frames.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_tx_flex.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter state encoding and
// parameter legality helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic bit data_bits_legal(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit os_rate_legal(input int n);
    return n >= 2;
  endfunction

  // Encoding 11 is reserved and behaves like "no parity".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts oversample ticks and flags the tick that closes
// a bit period. bit_end is combinational so the caller can move to the next
// bit on the very edge that sees the last tick.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OS_RATE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic s_tick,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(OS_RATE - 1);

  logic [CW-1:0] tick_cnt_reg;

  // While cleared (transmitter idle) ticks are ignored entirely.
  assign bit_end = !clear && s_tick && (tick_cnt_reg == LAST_TICK);

  // Tick counter: restarts on clear and on each completed bit, never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick_cnt_reg <= '0;
    end else if (s_tick) begin
      if (tick_cnt_reg == LAST_TICK) begin
        tick_cnt_reg <= '0;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_flex.sv
// Parametrised UART transmitter: DATA_BITS LSB-first, optional even/odd
// parity, 1 or 2 stop bits chosen per frame, one-entry holding buffer so
// frames can go out back-to-back with no idle gap.
module uart_tx_flex
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tick,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_tx_flex: DATA_BITS must be 5..9");
  end
  if (!os_rate_legal(OS_RATE)) begin : g_bad_os_rate
    $error("uart_tx_flex: OS_RATE must be >= 2");
  end

  // Holding buffer
  logic [DATA_BITS-1:0] buf_data_reg;
  logic [1:0]           buf_parity_reg;
  logic                 buf_stop2_reg;
  logic                 buf_full_reg, buf_full_next;
  logic                 ready_reg;
  logic                 accept;
  logic                 load;

  // Frame in flight
  tx_state_t            state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_en_reg, par_en_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 stop2_reg, stop2_next;
  logic [BCW-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;
  logic                 bit_end;

  uart_bit_timer #(
    .OS_RATE(OS_RATE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .s_tick (s_tick),
    .clear  (state_reg == ST_IDLE),
    .bit_end(bit_end)
  );

  // ready mirrors "buffer empty", so accept and load can never coincide.
  assign accept = tx_valid && ready_reg;

  // Buffer occupancy for the next cycle.
  always_comb begin
    buf_full_next = buf_full_reg;
    if (accept) begin
      buf_full_next = 1'b1;
    end else if (load) begin
      buf_full_next = 1'b0;
    end
  end

  // Holding buffer: captures payload and frame config together on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_reg   <= 1'b0;
      ready_reg      <= 1'b1;
      buf_data_reg   <= '0;
      buf_parity_reg <= PAR_NONE;
      buf_stop2_reg  <= 1'b0;
    end else begin
      if (accept) begin
        buf_data_reg   <= tx_data;
        buf_parity_reg <= cfg_parity;
        buf_stop2_reg  <= cfg_stop2;
      end
      buf_full_reg <= buf_full_next;
      ready_reg    <= !buf_full_next;
    end
  end

  // Next-state and output logic; a buffer load overrides everything else.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
    stop2_next    = stop2_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    tx_next       = tx_reg;
    done_next     = 1'b0;
    load          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (buf_full_reg) begin
          load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next   = ST_DATA;
          tx_next      = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            if (par_en_reg) begin
              state_next = ST_PARITY;
              tx_next    = par_bit_reg;
            end else begin
              state_next    = ST_STOP;
              tx_next       = 1'b1;
              stop_cnt_next = 1'b0;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            tx_next      = shift_reg[0];
            shift_next   = shift_reg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_next    = ST_STOP;
          tx_next       = 1'b1;
          stop_cnt_next = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_reg && !stop_cnt_reg) begin
            stop_cnt_next = 1'b1;
          end else begin
            done_next = 1'b1;
            if (buf_full_reg) begin
              load = 1'b1;
            end else begin
              state_next = ST_IDLE;
              tx_next    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Start bit goes out on the load edge; parity is precomputed here.
    if (load) begin
      state_next    = ST_START;
      tx_next       = 1'b0;
      shift_next    = buf_data_reg;
      par_en_next   = parity_enabled(buf_parity_reg);
      par_bit_next  = (buf_parity_reg == PAR_ODD) ? ~^buf_data_reg : ^buf_data_reg;
      stop2_next    = buf_stop2_reg;
      bit_cnt_next  = '0;
      stop_cnt_next = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      par_en_reg   <= par_en_next;
      par_bit_reg  <= par_bit_next;
      stop2_reg    <= stop2_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
    end
  end

  assign tx       = tx_reg;
  assign tx_ready = ready_reg;
  assign tx_busy  = (state_reg != ST_IDLE);
  assign tx_done  = done_reg;

endmodule
